// File: rtl/mux_sel_ctrl_if.sv
// Command and write-port bundle between the channel-select sequencer and its environment.
// The sequencer side (master) receives the mode/step/force controls and drives the write port.
// The downstream side (slave) drives the controls and observes the write port.
interface mux_sel_ctrl_if;
  logic       auto_en;   // level: 1 = auto-scan, 0 = manual
  logic       hold;      // level: freeze the dwell counter in auto-scan
  logic       step;      // pulse: advance to the next channel
  logic       force_en;  // pulse: load force_ch
  logic [1:0] force_ch;  // channel loaded on force_en
  logic       wr;        // single-cycle write strobe to the downstream mux
  logic [1:0] data_wr;   // channel value, valid while wr=1
  logic [1:0] ch_cur;    // currently commanded channel

  modport master (
    input  auto_en, hold, step, force_en, force_ch,
    output wr, data_wr, ch_cur
  );

  modport slave (
    output auto_en, hold, step, force_en, force_ch,
    input  wr, data_wr, ch_cur
  );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Channel-select sequencer driving the write port of a 4:1 select-register mux.
// Latency: an event sampled at edge N gives wr=1 with the new channel during cycle N+1.
// No backpressure: the downstream register always accepts; lower-priority same-cycle events are dropped.
module mux_sel_ctrl #(
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sel_ctrl_if.master       bus
);

  localparam int unsigned CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_MANUAL = 2'd1,
    S_AUTO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    data_q, data_d;

  // State, channel, dwell counter and write-port registers; reset kills any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: force beats step beats dwell expiry, so at most one write is issued per cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    data_d  = data_q;

    unique case (state_q)
      // First cycle after reset: rewrite channel 0 so the downstream register matches ch_cur.
      S_INIT: begin
        wr_d    = 1'b1;
        ch_d    = 2'd0;
        cnt_d   = '0;
        state_d = bus.auto_en ? S_AUTO : S_MANUAL;
      end

      S_MANUAL: begin
        cnt_d = '0;
        if (bus.auto_en) begin
          state_d = S_AUTO;
        end
        if (bus.force_en) begin
          ch_d = bus.force_ch;
          wr_d = 1'b1;
        end else if (bus.step) begin
          ch_d = ch_q + 2'd1;
          wr_d = 1'b1;
        end
      end

      S_AUTO: begin
        // Leaving auto-scan takes precedence over a coincident dwell expiry.
        if (!bus.auto_en) begin
          state_d = S_MANUAL;
          cnt_d   = '0;
        end
        if (bus.force_en) begin
          ch_d  = bus.force_ch;
          wr_d  = 1'b1;
          cnt_d = '0;
        end else if (bus.step) begin
          ch_d  = ch_q + 2'd1;
          wr_d  = 1'b1;
          cnt_d = '0;
        end else if (bus.auto_en && !bus.hold) begin
          if (cnt_q == TERM) begin
            ch_d  = ch_q + 2'd1;
            wr_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // data_wr only moves with a write and otherwise holds its last value.
    if (wr_d) begin
      data_d = ch_d;
    end
  end

  assign bus.wr      = wr_q;
  assign bus.data_wr = data_q;
  assign bus.ch_cur  = ch_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl with DWELL_CYCLES=4.
// Every expected write (cycle and channel) is queued when its cause is driven; a monitor pops and compares.
// Cycle numbering: cyc counts rising edges; outputs are sampled on the falling edge.
module tb_mux_sel_ctrl;

  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   b;

  typedef struct {
    int         cyc;
    logic [1:0] data;
  } exp_t;

  exp_t sb[$];

  mux_sel_ctrl_if bus_if ();

  mux_sel_ctrl #(.DWELL_CYCLES(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
  endtask

  // Scoreboard monitor: every write must match the head of the queue in cycle and channel,
  // and an expected write whose cycle has passed without a strobe is reported as missing.
  always @(negedge clk) begin
    exp_t e;
    if (bus_if.wr === 1'b1) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
      end else begin
        e.cyc  = -1;
        e.data = 2'bxx;
      end
      n_total++;
      assert ({cyc, bus_if.data_wr} === {e.cyc, e.data}) n_pass++;
      else $error("FAIL wr_event: observed cycle %0d data_wr %0d, expected cycle %0d data_wr %0d",
                  cyc, bus_if.data_wr, e.cyc, e.data);
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      assert (bus_if.wr === 1'b1) n_pass++;
      else $error("FAIL missing_wr: observed wr %0d at cycle %0d, expected wr 1 data_wr %0d at cycle %0d",
                  bus_if.wr, cyc, e.data, e.cyc);
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus_if.auto_en  = 1'b0;
    bus_if.hold     = 1'b0;
    bus_if.step     = 1'b0;
    bus_if.force_en = 1'b0;
    bus_if.force_ch = 2'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_wr", 32'(bus_if.wr), 0);
    chk("rst_data_wr", 32'(bus_if.data_wr), 0);
    chk("rst_ch_cur", 32'(bus_if.ch_cur), 0);

    // Release in manual mode: one realignment write of channel 0, then quiet.
    push(cyc + 1, 2'd0);
    rst_n = 1'b1;
    b = cyc;
    wait_cyc(b + 21);
    chk("manual_idle_ch", 32'(bus_if.ch_cur), 0);

    // Manual stepping, including 3->0 wrap.
    for (int k = 1; k <= 4; k++) begin
      push(cyc + 1, 2'(k % 4));
      bus_if.step = 1'b1;
      @(negedge clk);
      bus_if.step = 1'b0;
      repeat (2) @(negedge clk);
      chk("manual_step_ch", 32'(bus_if.ch_cur), 32'(k % 4));
    end

    // Auto-scan: first timed write 4 edges after the mode change, then every 4.
    b = cyc;
    bus_if.auto_en = 1'b1;
    push(b + 5, 2'd1);
    push(b + 9, 2'd2);
    push(b + 13, 2'd3);
    push(b + 17, 2'd0);
    push(b + 21, 2'd1);
    wait_cyc(b + 22);

    // Hold for 6 edges mid-dwell: the next write moves from b+25 to b+31.
    push(b + 31, 2'd2);
    bus_if.hold = 1'b1;
    wait_cyc(b + 28);
    chk("hold_ch", 32'(bus_if.ch_cur), 1);
    bus_if.hold = 1'b0;
    push(b + 35, 2'd3);
    push(b + 39, 2'd0);
    wait_cyc(b + 40);

    // Force and step together at ch 0: force wins, one write of 2.
    chk("pre_force_ch", 32'(bus_if.ch_cur), 0);
    push(b + 41, 2'd2);
    bus_if.force_en = 1'b1;
    bus_if.force_ch = 2'd2;
    bus_if.step     = 1'b1;
    wait_cyc(b + 41);
    // Same channel forced again: still written, and the dwell restarts.
    bus_if.step = 1'b0;
    push(b + 42, 2'd2);
    wait_cyc(b + 42);
    bus_if.force_en = 1'b0;
    push(b + 46, 2'd3);
    push(b + 50, 2'd0);
    push(b + 54, 2'd1);
    wait_cyc(b + 57);

    // Step lands on the dwell terminal count at ch 1: single write of 2, dwell restarts.
    chk("pre_collide_ch", 32'(bus_if.ch_cur), 1);
    push(b + 58, 2'd2);
    bus_if.step = 1'b1;
    wait_cyc(b + 58);
    bus_if.step = 1'b0;
    push(b + 62, 2'd3);
    wait_cyc(b + 61);
    chk("collide_ch", 32'(bus_if.ch_cur), 2);
    wait_cyc(b + 62);

    // Reset while the write of channel 3 is on the port: everything clears at once.
    chk("pre_reset_ch", 32'(bus_if.ch_cur), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", 32'(bus_if.wr), 0);
    chk("midrst_data_wr", 32'(bus_if.data_wr), 0);
    chk("midrst_ch_cur", 32'(bus_if.ch_cur), 0);
    wait_cyc(b + 64);
    push(b + 65, 2'd0);
    push(b + 69, 2'd1);
    push(b + 73, 2'd2);
    rst_n = 1'b1;
    wait_cyc(b + 75);
    chk("post_reset_ch", 32'(bus_if.ch_cur), 2);

    // Leave auto-scan: no write, channel retained, no further timed advances.
    bus_if.auto_en = 1'b0;
    wait_cyc(b + 86);
    chk("manual_retain_ch", 32'(bus_if.ch_cur), 2);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
Channel-select sequencer that drives the write port (wr, data_wr) of the 4:1 select-register mux directly downstream. Supports manual stepping, timed auto-scan across the four channels, and direct channel forcing. Guarantees exactly one single-cycle write per selection change and resynchronises the downstream select register after every reset.

Parameters:
DWELL_CYCLES, 50000000, clock cycles each channel stays selected in auto-scan (minimum 2); counter width is $clog2(DWELL_CYCLES).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
auto_en  input  1  level; 1 = auto-scan mode, 0 = manual mode
hold  input  1  level; freezes the dwell counter while in auto mode
step  input  1  single-cycle pulse; advance to the next channel
force_en  input  1  single-cycle pulse; load force_ch
force_ch  input  2  channel loaded on force_en
wr  output  1  single-cycle write strobe to downstream mux
data_wr  output  2  channel value; valid when wr=1
ch_cur  output  2  currently commanded channel

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values: wr=0, data_wr=0, ch_cur=0, dwell counter=0, state=S_INIT.
- States:
  - S_INIT: entered only via reset. At the first clk edge after rst_n deasserts: wr=1, data_wr=0, then go to S_AUTO if auto_en=1, otherwise S_MANUAL. Inputs are ignored in this cycle.
  - S_MANUAL: no timed advance; dwell counter held at 0.
  - S_AUTO: dwell counter increments each cycle while hold=0.
- Advance rule: ch_cur <= ch_cur+1 mod 4. Wrap-around 3->0 is required.
- Latency: an event sampled at edge N gives wr=1 during cycle N+1 with data_wr equal to the new ch_cur. ch_cur updates on the same edge. wr returns to 0 the following cycle unless another event occurs.
- Events in priority order, at most one wr per cycle:
  1. force_en: ch_cur <= force_ch. wr is issued even if force_ch equals ch_cur. In S_AUTO the dwell counter is cleared.
  2. step: advance. Valid in both modes. In S_AUTO the dwell counter is cleared.
  3. Dwell expiry, S_AUTO only: when the counter reaches DWELL_CYCLES-1 with hold=0, advance and clear the counter to 0.
- Lower-priority events in the same cycle are discarded, not queued.
- Dwell period: in uninterrupted auto-scan, consecutive wr pulses are exactly DWELL_CYCLES cycles apart.
- hold=1 in S_AUTO freezes the counter value. It does not block force_en or step. Releasing hold resumes counting from the frozen value.
- Mode transitions:
  - auto_en 0->1 (S_MANUAL->S_AUTO): counter cleared, no wr. The first timed advance follows DWELL_CYCLES cycles later.
  - auto_en 1->0: go to S_MANUAL, counter cleared, no wr; ch_cur retained.
  - A force or step sampled in the same cycle as a mode change is still honoured.
- Reset mid-operation: all registers clear immediately and asynchronously, including any wr in flight. After release, the S_INIT write re-aligns the downstream select register to channel 0.
- No other wr sources exist. data_wr holds its last value when wr=0.

Test Plan (DWELL_CYCLES=4):
- Reset release with auto_en=0 -> wr=1, data_wr=0 at first edge; then wr=0 and ch_cur=0 steady for 20 cycles.
- Manual: four step pulses 3 cycles apart -> wr pulses with data_wr 1,2,3,0 (wrap), each one cycle after its step.
- Auto: auto_en=1 held -> wr every 4 cycles with data_wr 1,2,3,0,1. hold=1 for 6 cycles mid-dwell -> next wr delayed by exactly 6 cycles.
- Priority: force_en with force_ch=2 and step in the same cycle while ch_cur=0 -> single wr, data_wr=2. force_ch=2 again next -> wr=1, data_wr=2, counter cleared.
- Expiry collision: step coincides with the dwell terminal count at ch_cur=1 -> one wr, data_wr=2; next timed wr 4 cycles later with data_wr=3.
- rst_n asserted for 2 cycles during auto-scan at ch_cur=3 -> outputs zero immediately; after release wr=1, data_wr=0; auto-scan resumes, first advance 4 cycles later.
